// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampling tick generator, 3-sample majority vote
// at bit centre. Delivers each byte as a one-cycle strobe and flags bad stop bits.
module uart_rx_byte #(
    parameter int unsigned CLOCK_RATE = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RsRx,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned TICK_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DW       = $clog2(TICK_DIV + 1);
    localparam int unsigned PW       = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_S0    = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1    = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_S2    = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [PW-1:0] PH_VOTE  = PW'(OVERSAMPLE / 2 + 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e         state_q, state_d;
    logic           rx_meta_q, rx_s_q;
    logic [DW-1:0]  div_q, div_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]     samp_q, samp_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           tick, vote, vote_now;

    assign tick     = (div_q == DIV_LAST);
    assign div_d    = tick ? '0 : div_q + DW'(1);
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign vote_now = tick && (phase_q == PH_VOTE);

    // Phase runs modulo OVERSAMPLE from start detection, so every later vote lands exactly one
    // bit time after the previous one without restarting the counter.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        if (tick) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
            if (phase_q == PH_S0 || phase_q == PH_S1 || phase_q == PH_S2) begin
                samp_d = {samp_q[1:0], rx_s_q};
            end
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d = StStart;
                        phase_d = '0;
                    end
                end
                StStart: begin
                    if (vote_now) begin
                        if (vote) begin
                            state_d = StIdle;
                        end else begin
                            state_d   = StData;
                            bit_cnt_d = '0;
                        end
                    end
                end
                StData: begin
                    if (vote_now) begin
                        shift_d   = {vote, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = StStop;
                    end
                end
                StStop: begin
                    if (vote_now) begin
                        if (vote) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rx_s_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            div_q     <= '0;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= RsRx;
            rx_s_q    <= rx_meta_q;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: 160-cycle bits, back-to-back frames, glitch, break,
// majority spike rejection and mid-frame reset.
module tb_uart_rx_byte;

    localparam int unsigned BIT = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       RsRx;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_error;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    int v_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    logic [7:0] vdata [0:63];

    uart_rx_byte #(
        .CLOCK_RATE(1_600_000),
        .BAUD_RATE (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RsRx       (RsRx),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out) begin
            if (v_cnt < 64) vdata[v_cnt] = data_out;
            v_cnt = v_cnt + 1;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (valid_out && frame_error) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        RsRx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Bit index i: 0 start, 1..8 data LSB first, 9 stop. spike_bit drives a 5-cycle low pulse
    // around the centre of that bit index (-1 for none).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BIT; c++) begin
                if (i == spike_bit && c >= 78 && c < 83) RsRx = 1'b0;
                else RsRx = frame[i];
                @(negedge clk);
            end
        end
    endtask

    int v0, f0;

    initial begin
        reset = 1'b0;
        RsRx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        idle(2000);
        check("idle_valid_cnt", v_cnt, 0);
        check("idle_ferr_cnt", fe_cnt, 0);

        // Back-to-back frames.
        v0 = v_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hA3, 1'b1, -1);
        idle(2 * BIT);
        check("b2b_count", v_cnt - v0, 2);
        check("b2b_first", {24'd0, vdata[v0]}, 32'h55);
        check("b2b_second", {24'd0, vdata[v0 + 1]}, 32'hA3);
        check("b2b_ferr", fe_cnt - f0, 0);

        // Short start glitch.
        v0 = v_cnt; f0 = fe_cnt;
        RsRx = 1'b0;
        repeat (40) @(negedge clk);
        idle(BIT);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_valid", v_cnt - v0, 0);
        check("glitch_ferr", fe_cnt - f0, 0);
        send_frame(8'h0F, 1'b1, -1);
        idle(BIT);
        check("post_glitch_count", v_cnt - v0, 1);
        check("post_glitch_data", {24'd0, data_out}, 32'h0F);

        // Framing error followed by a break.
        v0 = v_cnt; f0 = fe_cnt;
        send_frame(8'h31, 1'b0, -1);
        RsRx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check("break_ferr", fe_cnt - f0, 1);
        check("break_valid", v_cnt - v0, 0);
        check("break_data_hold", {24'd0, data_out}, 32'h0F);
        check("break_busy", {31'd0, busy}, 32'd1);
        idle(2 * BIT);
        check("break_exit_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h7E, 1'b1, -1);
        idle(BIT);
        check("after_break_count", v_cnt - v0, 1);
        check("after_break_data", {24'd0, data_out}, 32'h7E);
        check("after_break_ferr", fe_cnt - f0, 1);

        // Spike in the middle of data bit 2 (value 1).
        v0 = v_cnt;
        send_frame(8'hC4, 1'b1, 3);
        idle(BIT);
        check("spike_count", v_cnt - v0, 1);
        check("spike_data", {24'd0, data_out}, 32'hC4);

        // Reset midway through bit 4 of 0xFF.
        v0 = v_cnt; f0 = fe_cnt;
        RsRx = 1'b0;
        repeat (BIT) @(negedge clk);
        RsRx = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_data", {24'd0, data_out}, 32'h00);
        idle(6 * BIT);
        check("mrst_valid", v_cnt - v0, 0);
        check("mrst_ferr", fe_cnt - f0, 0);
        send_frame(8'h12, 1'b1, -1);
        idle(BIT);
        check("mrst_next_count", v_cnt - v0, 1);
        check("mrst_next_data", {24'd0, data_out}, 32'h12);

        check("never_both", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial UART receiver that recovers 8N1 bytes from the RsRx pin. It delivers each byte as a one-cycle strobe to the hex-digit input manager sitting directly downstream, which accumulates digits into the 16-bit FSM operand. The receiver oversamples the line, majority-votes at bit centre, and flags framing errors. It never stalls: the consumer must accept a byte in the strobe cycle.

Parameters:
CLOCK_RATE, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in baud
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
(derived) TICK_DIV = CLOCK_RATE / (BAUD_RATE*OVERSAMPLE), integer division; 651 at defaults

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge
RsRx  input  1  asynchronous serial line, idle high
data_out  output  8  last correctly framed byte, LSB received first
valid_out  output  1  one-cycle pulse: data_out updated this cycle
frame_error  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; sync flops = 1; tick divider, tick counter, bit counter, shift register = 0. data_out = 0, valid_out = 0, frame_error = 0, busy = 0. Reset overrides everything, including mid-byte; the partial byte is discarded with no pulse.
- Synchronizer: RsRx passes through 2 flops (rx_s); all decisions use rx_s.
- Tick generator: free-running counter 0..TICK_DIV-1. tick is high for one cycle when the counter equals TICK_DIV-1, then it wraps to 0. Not restarted on start detection, so start-detect jitter is at most 1 tick.
- Majority vote: on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of a bit, capture rx_s. Bit value = majority of the 3 samples, evaluated on the tick after the last sample.
- States:
  - IDLE: busy=0. On a tick with rx_s==0: go to START, tick_cnt=0.
  - START: count ticks. At vote time, if vote==0: go to DATA, tick_cnt=0, bit_cnt=0. If vote==1 (glitch): go to IDLE with no output.
  - DATA: every OVERSAMPLE ticks measured from the start-bit vote point, vote the bit and shift it in LSB-first. After bit 7: go to STOP.
  - STOP: vote the stop bit. If 1: data_out <= shift register, valid_out=1 for exactly one cycle, go to IDLE. If 0: frame_error=1 for one cycle, data_out unchanged, go to BREAK.
  - BREAK: wait until rx_s==1 on a tick, then go to IDLE. Any low time (a break) produces no further pulses.
- valid_out and frame_error are never high together. Each fires at most once per frame.
- Latency: the pulse is asserted on the clk cycle after the stop-bit vote, about 9.5 bit times after the start edge.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge be caught with no lost byte.
- data_out holds its value between pulses; the consumer may sample it at any time.

Test Plan:
(Bench parameters: CLOCK_RATE=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving TICK_DIV=10 and a 160-cycle bit.)
1. reset low for 3 cycles, RsRx=1 -> data_out=0x00, valid_out=0, frame_error=0, busy=0. Idle for 2000 cycles -> no pulses.
2. Send 0x55, then 0xA3 immediately back-to-back -> exactly two valid_out pulses: data_out=0x55, then 0xA3. frame_error never asserted.
3. Drive RsRx low for 40 cycles, then high -> no valid_out, no frame_error, busy returns to 0 within 1 bit time. A following 0x0F is received correctly.
4. Send 0x31 with stop bit 0, hold the line low for 3 more bit times, then send 0x7E -> one frame_error pulse, data_out stays at its prior value, no valid_out during the low period, then valid_out with data_out=0x7E.
5. Send 0xC4 with a 5-cycle low spike at the centre of bit 2 (a 1 bit) -> majority rejects the spike, data_out=0xC4.
6. Assert reset for 1 cycle midway through bit 4 of 0xFF -> busy=0 and no pulse from that frame. A following 0x12, sent after line idle, is received correctly.
